// File: rtl/char_transmit_control_pkg.sv
// Shared UART constants and the transmitter state type.
// The receive path imports the same constants.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = DATA_BITS + 2;
  localparam int BSC_W      = $clog2(OVERSAMPLE);
  localparam int BIC_W      = 4;

  localparam logic [BIC_W-1:0] STOP_BIC      = BIC_W'(FRAME_BITS - 1);
  localparam logic [BIC_W-1:0] LAST_DATA_BIC = BIC_W'(DATA_BITS);
  localparam logic [BSC_W-1:0] LAST_BSC      = BSC_W'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/char_transmit_control_if.sv
// Processor-side data port plus serial line and bit-position status.
interface char_transmit_control_if;

  logic                           tick;
  logic                           load;
  logic [uart_pkg::DATA_BITS-1:0] txData;
  logic                           ready;
  logic                           busy;
  logic                           serialOut;
  logic                           charSent;
  logic [uart_pkg::BIC_W-1:0]     BIC;
  logic [uart_pkg::BSC_W-1:0]     BSC;

  modport master (
    output tick, load, txData,
    input  ready, busy, serialOut, charSent, BIC, BSC
  );

  modport slave (
    input  tick, load, txData,
    output ready, busy, serialOut, charSent, BIC, BSC
  );

endinterface

// File: rtl/char_transmit_control_bit_counter.sv
// Combined bit identification / bit sample counter for the transmitter.
// BSC counts oversample ticks inside a bit, BIC counts bits inside a frame.
module tx_bit_counter
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [BIC_W-1:0] bic_o,
  output logic [BSC_W-1:0] bsc_o,
  output logic             bitDone_o,
  output logic             frameDone_o
);

  logic [BIC_W-1:0] bic_q, bic_d;
  logic [BSC_W-1:0] bsc_q, bsc_d;
  logic             step;

  assign step        = en_i && tick_i;
  assign bitDone_o   = step && (bsc_q == LAST_BSC);
  assign frameDone_o = bitDone_o && (bic_q == STOP_BIC);
  assign bic_o       = bic_q;
  assign bsc_o       = bsc_q;

  // Next count: clear wins, otherwise advance BSC on a tick and BIC on its wrap.
  always_comb begin
    bic_d = bic_q;
    bsc_d = bsc_q;
    if (clr_i) begin
      bic_d = '0;
      bsc_d = '0;
    end else if (step) begin
      bsc_d = bsc_q + BSC_W'(1);
      if (bitDone_o) bic_d = bic_q + BIC_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bic_q <= '0;
      bsc_q <= '0;
    end else begin
      bic_q <= bic_d;
      bsc_q <= bsc_d;
    end
  end

endmodule

// File: rtl/char_transmit_control.sv
// Serial character transmitter: one-deep holding register feeding a shift
// register that drives start, 8 data bits LSB first, and a stop bit.
module char_transmit_control
  import uart_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  char_transmit_control_if.slave bus
);

  tx_state_e              state_q;
  logic [DATA_BITS-1:0]   hold_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   ready_q;
  logic                   serial_q;
  logic                   charSent_q;

  logic [BIC_W-1:0]       bic;
  logic [BSC_W-1:0]       bsc;
  logic                   bit_done;
  logic                   frame_done;
  logic                   bic_bad;
  logic                   load_acc;
  logic                   cnt_clr;
  logic                   cnt_en;

  // ready is registered, so a load during a transfer edge sees ready=0.
  assign load_acc = bus.load && ready_q;
  assign bic_bad  = (bic > STOP_BIC);
  assign cnt_en   = (state_q != IDLE);
  // Hold counters at zero in IDLE; restart them at every frame boundary.
  assign cnt_clr  = (state_q == IDLE) || frame_done || bic_bad;

  tx_bit_counter u_cnt (
    .clk         (clk),
    .reset       (reset),
    .tick_i      (bus.tick),
    .en_i        (cnt_en),
    .clr_i       (cnt_clr),
    .bic_o       (bic),
    .bsc_o       (bsc),
    .bitDone_o   (bit_done),
    .frameDone_o (frame_done)
  );

  // Frame sequencing, holding/shift registers and the registered line driver.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      shift_q    <= '0;
      ready_q    <= 1'b1;
      serial_q   <= 1'b1;
      charSent_q <= 1'b0;
    end else begin
      charSent_q <= 1'b0;
      if (load_acc) begin
        hold_q  <= bus.txData;
        ready_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (!ready_q) begin
            shift_q  <= hold_q;
            ready_q  <= 1'b1;
            serial_q <= 1'b0;
            state_q  <= START;
          end
        end
        START, DATA, STOP: begin
          if (bic_bad) begin
            state_q  <= IDLE;
            serial_q <= 1'b1;
          end else if (frame_done) begin
            charSent_q <= 1'b1;
            if (!ready_q) begin
              // Next byte already waiting: start bit follows with no gap.
              shift_q  <= hold_q;
              ready_q  <= 1'b1;
              serial_q <= 1'b0;
              state_q  <= START;
            end else begin
              serial_q <= 1'b1;
              state_q  <= IDLE;
            end
          end else if (bit_done) begin
            if (bic == LAST_DATA_BIC) begin
              serial_q <= 1'b1;
              state_q  <= STOP;
            end else begin
              serial_q <= shift_q[0];
              shift_q  <= shift_q >> 1;
              state_q  <= DATA;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          serial_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.serialOut = serial_q;
  assign bus.charSent  = charSent_q;
  assign bus.BIC       = bic;
  assign bus.BSC       = bsc;

endmodule

// File: tb/tb_char_transmit_control.sv
// Directed bench for char_transmit_control with a byte scoreboard and an
// independent tick-counting line monitor.
module tb_char_transmit_control;

  logic clk;
  logic reset;

  char_transmit_control_if bus ();

  char_transmit_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  logic [7:0] exp_q[$];    // bytes expected on the line, in order
  int         cs_ticks[$]; // tick count at each charSent pulse
  int         cs_cnt = 0;
  int         tick_total = 0;
  int         mode = 0;    // 0: every 4 clocks, 1: irregular, 2: every clock
  int         gcyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic next_tick(output logic t);
    case (mode)
      0:       t = ((gcyc % 4) == 0);
      1:       t = ($urandom_range(0, 2) != 0);
      default: t = 1'b1;
    endcase
    gcyc++;
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic step(input logic ld, input logic [7:0] d);
    logic t;
    @(posedge clk);
    #1;
    next_tick(t);
    bus.tick   = t;
    bus.load   = ld;
    bus.txData = d;
  endtask

  // Load from IDLE and check the two-edge handoff timing.
  task automatic load_idle(input logic [7:0] d);
    exp_q.push_back(d);
    step(1'b1, d);
    step(1'b0, 8'h00);
    chk("ready_after_load", 32'(bus.ready), 32'd0);
    step(1'b0, 8'h00);
    chk("start_serial", 32'(bus.serialOut), 32'd0);
    chk("start_busy", 32'(bus.busy), 32'd1);
    chk("start_ready", 32'(bus.ready), 32'd1);
  endtask

  task automatic wait_frames(input int target, input int limit);
    int n;
    n = 0;
    while (cs_cnt < target && n < limit) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk("frame_timeout", 32'(cs_cnt >= target), 32'd1);
  endtask

  // Line monitor: counts ticks itself from the start-bit edge.
  logic       in_frame = 1'b0;
  int         cnt = 0;
  logic [9:0] cur_frame = '0;

  always @(negedge clk) begin
    logic ended;
    ended = 1'b0;
    if (!reset) begin
      in_frame = 1'b0;
    end else begin
      if (in_frame && cnt == 160) begin
        chk("charSent_end", 32'(bus.charSent), 32'd1);
        cs_cnt++;
        cs_ticks.push_back(tick_total);
        in_frame = 1'b0;
        ended    = 1'b1;
      end
      if (!in_frame && bus.serialOut == 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
        end else begin
          cur_frame = {1'b1, exp_q.pop_front(), 1'b0};
          in_frame  = 1'b1;
          cnt       = 0;
        end
      end
      if (in_frame) begin
        chk("serial_bit", 32'(bus.serialOut), 32'(cur_frame[cnt / 16]));
        chk("BIC", 32'(bus.BIC), 32'(cnt / 16));
        chk("BSC", 32'(bus.BSC), 32'(cnt % 16));
        chk("busy_frame", 32'(bus.busy), 32'd1);
      end
      if (!ended) chk("charSent_quiet", 32'(bus.charSent), 32'd0);
      if (!in_frame && !ended) chk("idle_line", 32'(bus.serialOut), 32'd1);
      if (bus.tick) begin
        tick_total++;
        if (in_frame) cnt++;
      end
    end
  end

  initial begin
    int   n;
    int   snap;
    logic t;
    logic ld;
    logic hit;

    reset      = 1'b0;
    bus.tick   = 1'b0;
    bus.load   = 1'b0;
    bus.txData = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_serial", 32'(bus.serialOut), 32'd1);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_charSent", 32'(bus.charSent), 32'd0);
    chk("rst_BIC", 32'(bus.BIC), 32'd0);
    chk("rst_BSC", 32'(bus.BSC), 32'd0);
    reset = 1'b1;
    repeat (5) step(1'b0, 8'h00);

    // Single byte, tick every 4 clocks.
    mode = 0;
    load_idle(8'hA5);
    wait_frames(1, 1000);
    step(1'b0, 8'h00);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_ready", 32'(bus.ready), 32'd1);
    repeat (10) step(1'b0, 8'h00);

    // Back-to-back with ignored loads while full and at the reload edge.
    load_idle(8'h00);
    repeat (160) step(1'b0, 8'h00);
    exp_q.push_back(8'hFF);
    step(1'b1, 8'hFF);
    step(1'b0, 8'h00);
    chk("ready_full", 32'(bus.ready), 32'd0);
    step(1'b1, 8'h3C);
    step(1'b0, 8'h00);
    chk("ready_still_full", 32'(bus.ready), 32'd0);
    hit = 1'b0;
    n   = 0;
    while (!hit && n < 1000) begin
      @(posedge clk);
      #1;
      next_tick(t);
      ld = (bus.BIC == 4'd9) && (bus.BSC == 4'd15) && t;
      bus.tick   = t;
      bus.load   = ld;
      bus.txData = 8'h3C;
      if (ld) begin
        step(1'b0, 8'h00);
        chk("reload_ready", 32'(bus.ready), 32'd1);
        chk("reload_busy", 32'(bus.busy), 32'd1);
        chk("reload_serial", 32'(bus.serialOut), 32'd0);
        chk("reload_charSent", 32'(bus.charSent), 32'd1);
        hit = 1'b1;
      end
      n++;
    end
    chk("reload_edge_found", 32'(hit), 32'd1);
    wait_frames(3, 1000);
    if (cs_ticks.size() >= 3)
      chk("b2b_gap", 32'(cs_ticks[2] - cs_ticks[1]), 32'd160);
    else
      chk("b2b_pulses", 32'(cs_ticks.size()), 32'd3);
    repeat (10) step(1'b0, 8'h00);

    // Irregular tick spacing including back-to-back ticks.
    mode = 1;
    load_idle(8'h96);
    wait_frames(4, 1000);
    repeat (5) step(1'b0, 8'h00);

    // Tick on every clock.
    mode = 2;
    load_idle(8'h3C);
    wait_frames(5, 400);
    repeat (5) step(1'b0, 8'h00);

    // Reset in the middle of data bit 4.
    mode = 0;
    load_idle(8'h33);
    n = 0;
    while (!(bus.BIC == 4'd4 && bus.BSC == 4'd3) && n < 1000) begin
      step(1'b0, 8'h00);
      n++;
    end
    chk("reach_bic4", 32'(bus.BIC), 32'd4);
    snap = cs_cnt;
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_serial", 32'(bus.serialOut), 32'd1);
    chk("midrst_BIC", 32'(bus.BIC), 32'd0);
    chk("midrst_BSC", 32'(bus.BSC), 32'd0);
    chk("midrst_ready", 32'(bus.ready), 32'd1);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_charSent", 32'(bus.charSent), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (300) step(1'b0, 8'h00);
    chk("no_charSent_after_rst", 32'(cs_cnt), 32'(snap));
    chk("post_rst_serial", 32'(bus.serialOut), 32'd1);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/char_transmit_control.md
# char_transmit_control

Serial character transmitter: the transmit-side counterpart of the receive bit-count and shift-register control path. It accepts a parallel byte through a one-deep holding register and drives a 10-bit asynchronous frame on `serialOut`, least-significant data bit first. The frame is start (0), 8 data bits, then stop (1). Each bit lasts 16 oversample ticks, matching the receiver's 16x bit-sample count. The block sits between the processor-side data port and the serial line.

## Interface
- `OVERSAMPLE`, 16: ticks per bit; the BSC width is 4 bits.
- `DATA_BITS`, 8: data bits per frame; a frame is `DATA_BITS`+2 bits.
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low (0 = reset).
- `tick` in 1: oversample strobe, one `clk` cycle wide, at 16x baud.
- `load` in 1: write strobe for `txData`; accepted only when `ready`=1.
- `txData` in 8: byte to transmit; sampled on the accepting edge.
- `ready` out 1: holding register empty.
- `busy` out 1: a frame is in progress, i.e. state is not IDLE.
- `serialOut` out 1: serial line; idles high.
- `charSent` out 1: one-cycle pulse when the stop bit completes.
- `BIC` out 4: bit identification count; 0 = start, 1–8 = data, 9 = stop.
- `BSC` out 4: bit sample count within the current bit, 0–15.

## Operation
- **Reset values** (asserted asynchronously):
  - `serialOut`=1, `ready`=1, `busy`=0, `charSent`=0.
  - `BIC`=0, `BSC`=0, state IDLE.
  - Holding and shift registers cleared.
- **States:** IDLE, START, DATA, STOP.
- **Load:** `load`=1 and `ready`=1 captures `txData` into the holding register, and `ready`→0 at that edge.
  - `load` while `ready`=0 is ignored. Holding contents are never overwritten.
- **IDLE → START:** in IDLE with the holding register full, the next edge does all of the following:
  - moves the holding byte into the shift register; `ready`→1;
  - clears `BIC` and `BSC` to 0;
  - drives `serialOut`=0.
  - This happens regardless of `tick`.
- **Counting:**
  - Each `tick` increments `BSC`.
  - A `tick` with `BSC`=15 wraps `BSC` to 0, increments `BIC`, and updates `serialOut` to the next bit.
  - `BIC` 1→8 drives `shift[0]`, then shifts right.
  - `BIC`=9 drives 1 (stop bit).
- **State tracking:** START while `BIC`=0, DATA while `BIC`=1..8, STOP while `BIC`=9.
- **End of frame:** a `tick` with `BIC`=9 and `BSC`=15 pulses `charSent` for exactly one cycle. Then:
  - If the holding register is full, go to START at the same edge: reload shift, `BIC`=`BSC`=0, `serialOut`=0. There is no idle gap between frames.
  - Otherwise go to IDLE with `serialOut`=1.
- **Simultaneous load and transfer:** a `load` in the same cycle as a transfer or end-of-frame reload is ignored, because `ready` is registered and still 0.
- **Arithmetic:** `BSC` is 4-bit and wraps modulo 16. `BIC` never exceeds 9; 10–15 are unreachable.
  - Any illegal encoding returns to IDLE on the next edge.
- **Reset mid-frame:** the line returns high immediately and the frame is abandoned with no `charSent` pulse.

## Timing
- `load` accepted at edge N (IDLE, `ready`=1):
  - edge N: `ready`=0;
  - edge N+1: `serialOut`=0, `busy`=1, `ready`=1.
- Frame length is exactly 160 ticks from the START edge to the stop-bit end.
- `serialOut` changes only on the START edge, on tick edges where `BSC` wraps, and on reset. It is glitch-free because it is registered.
- `charSent` is asserted in the cycle after the final tick edge; `busy` falls at the same edge if IDLE is entered.

## Structure
- **Shared package** `uart_pkg`, which holds:
  - the state enum (IDLE, START, DATA, STOP);
  - `OVERSAMPLE`, `FRAME_BITS`=10, `STOP_BIC`=9, `LAST_BSC`=15.
  - The receiver side reuses these constants.
- **Sub-module** `tx_bit_counter`: the combined `BIC`/`BSC` counter with a tick enable, synchronous clear, and a `bitDone`/`frameDone` strobe.
- The top level holds the FSM, holding register, shift register, and line driver.

## Test plan
- **Reset:** assert `reset`=0 mid-frame at `BIC`=4 → `serialOut`=1, `BIC`=`BSC`=0, `ready`=1 immediately; no `charSent`.
- **Single byte:** load 0xA5, tick every 4 clocks → line carries 0, 1,0,1,0,0,1,0,1, 1 with 16 ticks per bit. `charSent` pulses once after tick 160; then IDLE.
- **Back-to-back:** load 0x00, then 0xFF while the first frame is in DATA → second start bit begins at the same edge as the first frame's stop-bit end. Two `charSent` pulses, 160 ticks apart.
- **Load while full:** holding register full, pulse `load` with 0x3C → ignored; the original byte is transmitted.
- **Tick gaps:** irregular `tick` spacing including back-to-back ticks → bit boundaries follow the tick count, not the clock count; `BSC` wraps 15→0.
- **Load at end-of-frame edge:** `load` asserted in the same cycle as the reload transfer → ignored; `ready` rises the following cycle.
